// File: rtl/wb_bus_decoder.sv
// Single-master Wishbone address decoder with unmapped/timeout error synthesis
// and a sticky error-status record for software and debug.
module wb_bus_decoder #(
    parameter int                  N_SLV       = 4,
    parameter logic [N_SLV*32-1:0] SLV_BASE    = {32'h2000_0200, 32'h2000_0100, 32'h2000_0000, 32'h0000_0000},
    parameter logic [N_SLV*32-1:0] SLV_MASK    = {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hF000_0000},
    parameter int                  TIMEOUT_CYC = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         m_adr_i,
    input  logic [31:0]         m_dat_i,
    input  logic [3:0]          m_sel_i,
    input  logic                m_we_i,
    input  logic                m_cyc_i,
    input  logic                m_stb_i,
    output logic [31:0]         m_dat_o,
    output logic                m_ack_o,
    output logic                m_err_o,
    output logic [31:0]         s_adr_o,
    output logic [31:0]         s_dat_o,
    output logic [3:0]          s_sel_o,
    output logic                s_we_o,
    output logic [N_SLV-1:0]    s_cyc_o,
    output logic [N_SLV-1:0]    s_stb_o,
    input  logic [N_SLV*32-1:0] s_dat_i,
    input  logic [N_SLV-1:0]    s_ack_i,
    input  logic [N_SLV-1:0]    s_err_i,
    output logic                err_valid_o,
    output logic [1:0]          err_cause_o,
    output logic [31:0]         err_addr_o,
    input  logic                err_clr_i
);
    localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DERR} state_t;

    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic [7:0]       cnt;

    logic             hit;
    logic [SEL_W-1:0] hit_idx;
    logic [31:0]      sdat [N_SLV];
    logic [31:0]      sel_dat;
    logic             sel_ack, sel_err, rsp;
    logic             busy, live, tmo;
    logic [N_SLV-1:0] sel_oh;
    logic [1:0]       cause;

    for (genvar g = 0; g < N_SLV; g++) begin : g_unpack
        assign sdat[g] = s_dat_i[g*32 +: 32];
    end

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((m_adr_i & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign sel_dat = sdat[sel_q];
    assign sel_ack = s_ack_i[sel_q];
    assign sel_err = s_err_i[sel_q];
    assign rsp     = sel_ack | sel_err;
    assign sel_oh  = N_SLV'(1) << sel_q;

    // Outputs are gated by rst so a reset mid-access never leaks a response.
    assign busy = rst && (state == BUSY);
    assign live = busy && m_cyc_i;
    assign tmo  = live && !rsp && (cnt == 8'(TIMEOUT_CYC));

    assign s_cyc_o = (live && !tmo) ? sel_oh : '0;
    assign s_stb_o = (live && !tmo && m_stb_i) ? sel_oh : '0;
    assign m_ack_o = live && sel_ack && !sel_err;
    assign m_err_o = (live && (sel_err || tmo)) || (rst && state == DERR);
    assign m_dat_o = busy ? sel_dat : 32'h0;

    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;
    assign s_we_o  = m_we_i;

    assign cause = (state == DERR) ? 2'b01 : (tmo ? 2'b10 : 2'b11);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            sel_q       <= '0;
            cnt         <= '0;
            err_valid_o <= 1'b0;
            err_cause_o <= 2'b00;
            err_addr_o  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        if (hit) begin
                            sel_q <= hit_idx;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            state <= DERR;
                        end
                    end
                end
                BUSY: begin
                    if (!m_cyc_i || rsp || tmo) state <= IDLE;
                    else                        cnt   <= cnt + 8'd1;
                end
                DERR:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // A fresh error in the clearing cycle re-arms the record.
            if (m_err_o && (!err_valid_o || err_clr_i)) begin
                err_valid_o <= 1'b1;
                err_cause_o <= cause;
                err_addr_o  <= m_adr_i;
            end else if (err_clr_i) begin
                err_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_bus_decoder.sv
// Directed plus randomized bench for wb_bus_decoder; transactions are predicted
// from the address map and a per-transaction response plan.
module tb_wb_bus_decoder;
    localparam int TMO = 15;
    localparam logic [31:0] BASE [4] = '{32'h0000_0000, 32'h2000_0000, 32'h2000_0100, 32'h2000_0200};
    localparam logic [31:0] MASK [4] = '{32'hF000_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  m_adr_i, m_dat_i, m_dat_o, s_adr_o, s_dat_o, err_addr_o;
    logic [3:0]   m_sel_i, s_sel_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic         m_we_i, m_cyc_i, m_stb_i, m_ack_o, m_err_o, s_we_o;
    logic [127:0] s_dat_i;
    logic         err_valid_o, err_clr_i;
    logic [1:0]   err_cause_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic        mv;
    logic [1:0]  mcause;
    logic [31:0] maddr;

    wb_bus_decoder #(
        .N_SLV(4),
        .SLV_BASE({BASE[3], BASE[2], BASE[1], BASE[0]}),
        .SLV_MASK({MASK[3], MASK[2], MASK[1], MASK[0]}),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
        .m_err_o(m_err_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .err_valid_o(err_valid_o),
        .err_cause_o(err_cause_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int dec(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & MASK[i]) == BASE[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise(input int keep);
        for (int i = 0; i < 4; i++) begin
            if (i != keep) begin
                s_ack_i[i]          = 1'($urandom);
                s_err_i[i]          = 1'($urandom);
                s_dat_i[i*32 +: 32] = $urandom;
            end
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".err_valid"}, 32'(err_valid_o), 32'(mv));
        chk({tag, ".err_cause"}, 32'(err_cause_o), 32'(mcause));
        chk({tag, ".err_addr"}, err_addr_o, maddr);
    endtask

    // Status record rule: capture when empty or when cleared in the same cycle.
    task automatic model_status(input logic err, input logic [1:0] c, input logic [31:0] a, input logic clr);
        if (err && (!mv || clr)) begin
            mv = 1'b1; mcause = c; maddr = a;
        end else if (clr) begin
            mv = 1'b0;
        end
    endtask

    task automatic idle_cyc(input logic clr);
        tick();
        m_cyc_i = 1'b0; m_stb_i = 1'b0; err_clr_i = clr;
        noise(-1);
        #3;
        chk("idle.s_stb", 32'(s_stb_o), 32'h0);
        chk("idle.s_cyc", 32'(s_cyc_o), 32'h0);
        chk("idle.m_ack", 32'(m_ack_o), 32'h0);
        chk("idle.m_err", 32'(m_err_o), 32'h0);
        chk("idle.m_dat", m_dat_o, 32'h0);
        chk_status("idle");
        model_status(1'b0, 2'b00, 32'h0, clr);
    endtask

    // wt: wait cycles before the slave responds, -1 = never responds.
    task automatic run_txn(input logic [31:0] a, input logic we, input logic [3:0] sel,
                           input logic [31:0] wd, input int wt, input logic serr,
                           input logic both, input logic [31:0] rd, input logic clr_end,
                           input logic gap);
        int          e, last;
        logic        is_tmo, is_rsp;
        logic [1:0]  cause;
        logic [31:0] oh;
        e      = dec(a);
        is_rsp = (e >= 0) && (wt >= 0) && (wt <= TMO);
        is_tmo = (e >= 0) && !is_rsp;
        last   = (e < 0) ? 1 : (is_rsp ? wt + 1 : TMO + 1);
        cause  = (e < 0) ? 2'b01 : (is_tmo ? 2'b10 : 2'b11);
        oh     = (e >= 0) ? (32'h1 << e) : 32'h0;

        tick();
        m_adr_i = a; m_dat_i = wd; m_sel_i = sel; m_we_i = we;
        m_cyc_i = 1'b1; m_stb_i = 1'b1; err_clr_i = 1'b0;
        noise(-1);
        #3;
        chk("req.s_stb", 32'(s_stb_o), 32'h0);
        chk("req.m_ack", 32'(m_ack_o), 32'h0);
        chk("req.m_err", 32'(m_err_o), 32'h0);
        chk("req.s_adr", s_adr_o, a);
        chk("req.s_dat", s_dat_o, wd);
        chk("req.s_sel", 32'(s_sel_o), 32'(sel));
        chk("req.s_we", 32'(s_we_o), 32'(we));
        chk_status("req");

        for (int c = 1; c <= last; c++) begin
            logic fin;
            fin = (c == last);
            tick();
            noise(e);
            if (e >= 0) begin
                s_dat_i[e*32 +: 32] = rd;
                s_ack_i[e] = fin && is_rsp && (!serr || both);
                s_err_i[e] = fin && is_rsp && serr;
            end
            err_clr_i = fin && clr_end;
            #3;
            chk("txn.s_stb", 32'(s_stb_o), (fin && is_tmo) ? 32'h0 : oh);
            chk("txn.s_cyc", 32'(s_cyc_o), (fin && is_tmo) ? 32'h0 : oh);
            chk("txn.m_ack", 32'(m_ack_o), 32'(fin && is_rsp && !serr));
            chk("txn.m_err", 32'(m_err_o), 32'(fin && (!is_rsp || serr)));
            chk("txn.m_dat", m_dat_o, (e < 0) ? 32'h0 : rd);
            chk_status("txn");
            if (fin) model_status(!is_rsp || serr, cause, a, clr_end);
        end
        if (gap) idle_cyc(1'b0);
    endtask

    initial begin
        rst = 1'b0; m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = 1'b0;
        m_cyc_i = 1'b0; m_stb_i = 1'b0; s_dat_i = '0; s_ack_i = '0; s_err_i = '0;
        err_clr_i = 1'b0;
        mv = 1'b0; mcause = 2'b00; maddr = 32'h0;
        tick();
        noise(-1);
        #3;
        chk("rst.m_ack", 32'(m_ack_o), 32'h0);
        chk("rst.m_err", 32'(m_err_o), 32'h0);
        chk("rst.m_dat", m_dat_o, 32'h0);
        chk("rst.s_stb", 32'(s_stb_o), 32'h0);
        chk_status("rst");
        tick();
        rst = 1'b1;

        run_txn(32'h0000_0010, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        run_txn(32'h2000_0104, 1'b1, 4'b0011, 32'h1234_5678, 3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        run_txn(32'h4000_0000, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle_cyc(1'b1);
        run_txn(32'h2000_0200, 1'b0, 4'hF, 32'h0, -1, 1'b0, 1'b0, 32'h5555_AAAA, 1'b0, 1'b1);
        run_txn(32'h8000_0004, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle_cyc(1'b1);
        run_txn(32'h2000_0000, 1'b0, 4'hF, 32'h0, 1, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1);
        run_txn(32'h7000_0000, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            int          r, wt;
            logic [31:0] a;
            r = $urandom_range(0, 4);
            a = (r < 4) ? (BASE[r] | ($urandom & ~MASK[r])) : $urandom;
            wt = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TMO + 2);
            run_txn(a, 1'($urandom), 4'($urandom), $urandom, wt, ($urandom_range(0, 3) == 0),
                    1'($urandom), $urandom, ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        // Force a recorded error so the reset below has something to clear.
        run_txn(32'h9000_0000, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Master abandons a stalled slave-0 access in its third cycle.
        tick();
        m_adr_i = 32'h0000_0020; m_cyc_i = 1'b1; m_stb_i = 1'b1; err_clr_i = 1'b0;
        s_ack_i = '0; s_err_i = '0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin
                m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i[0] = 1'b1; s_err_i[0] = 1'b1;
            end
            #3;
            chk("abort.s_stb", 32'(s_stb_o), (c < 3) ? 32'h1 : 32'h0);
            chk("abort.m_ack", 32'(m_ack_o), 32'h0);
            chk("abort.m_err", 32'(m_err_o), 32'h0);
        end
        idle_cyc(1'b0);

        // Retry, then reset lands in the middle of it while the slave acks.
        tick();
        m_cyc_i = 1'b1; m_stb_i = 1'b1; s_ack_i = '0; s_err_i = '0;
        tick();
        #3;
        chk("retry.s_stb", 32'(s_stb_o), 32'h1);
        chk_status("retry");
        tick();
        rst = 1'b0; s_ack_i[0] = 1'b1;
        #3;
        chk("rstmid.m_ack", 32'(m_ack_o), 32'h0);
        chk("rstmid.m_err", 32'(m_err_o), 32'h0);
        chk("rstmid.s_stb", 32'(s_stb_o), 32'h0);
        mv = 1'b0; mcause = 2'b00; maddr = 32'h0;
        tick();
        rst = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0;
        #3;
        chk("post.m_ack", 32'(m_ack_o), 32'h0);
        chk("post.m_err", 32'(m_err_o), 32'h0);
        chk("post.m_dat", m_dat_o, 32'h0);
        chk("post.s_cyc", 32'(s_cyc_o), 32'h0);
        chk_status("post");
        run_txn(32'h2000_0110, 1'b0, 4'hF, 32'h0, 2, 1'b0, 1'b0, 32'h0BAD_C0DE, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_bus_decoder.md
# wb_bus_decoder

Single-master Wishbone decoder that sits directly downstream of the core/debug Wishbone controller. It decodes the master address onto one of `N_SLV` slave ports and returns that slave's data and ack to the master. It synthesises `m_err` for unmapped addresses and for slaves that never respond (bus timeout). It keeps a sticky error-status record for software and debug.

## Interface
Parameters:
- `N_SLV`, 4: number of slave ports; 1..8.
- `SLV_BASE`, {32'h2000_0200, 32'h2000_0100, 32'h2000_0000, 32'h0000_0000}: packed `N_SLV*32`; slave i base at bits [32i+31:32i].
- `SLV_MASK`, {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hF000_0000}: packed `N_SLV*32`; slave i matches when (addr & mask_i) == base_i.
- `TIMEOUT_CYC`, 15: BUSY cycles allowed before a timeout error; 1..255.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-low reset.
- `m_adr_i`, input, 32: master address.
- `m_dat_i`, input, 32: master write data.
- `m_sel_i`, input, 4: master byte enables.
- `m_we_i`, input, 1: master write enable.
- `m_cyc_i`, input, 1: master cycle.
- `m_stb_i`, input, 1: master strobe.
- `m_dat_o`, output, 32: read data to the master.
- `m_ack_o`, output, 1: acknowledge to the master.
- `m_err_o`, output, 1: error to the master.
- `s_adr_o`, output, 32: broadcast to all slaves.
- `s_dat_o`, output, 32: broadcast to all slaves.
- `s_sel_o`, output, 4: broadcast to all slaves.
- `s_we_o`, output, 1: broadcast to all slaves.
- `s_cyc_o`, output, `N_SLV`: per-slave cycle.
- `s_stb_o`, output, `N_SLV`: per-slave strobe.
- `s_dat_i`, input, `N_SLV*32`: slave read data, packed like `SLV_BASE`.
- `s_ack_i`, input, `N_SLV`: per-slave acknowledge.
- `s_err_i`, input, `N_SLV`: per-slave error.
- `err_valid_o`, output, 1: sticky error flag.
- `err_cause_o`, output, 2: 01 unmapped, 10 timeout, 11 slave error.
- `err_addr_o`, output, 32: address of the first unserviced error.
- `err_clr_i`, input, 1: clears `err_valid_o`.

## Operation
- States: IDLE, BUSY, DERR.
- **IDLE** with `m_cyc_i & m_stb_i`:
  - Decode the address; the lowest matching index wins.
  - On a match: register the slave index `sel_q`, clear the counter, go to BUSY.
  - No match: go to DERR.
  - No slave strobe is driven in IDLE.
- **BUSY**:
  - `s_cyc_o[sel_q]` = `m_cyc_i`; `s_stb_o[sel_q]` = `m_stb_i`; all other slave cyc/stb bits are 0.
  - `m_dat_o` = `s_dat_i[sel_q]`; `m_ack_o` = `s_ack_i[sel_q]`; `m_err_o` = `s_err_i[sel_q]` | timeout.
  - On ack or error, go to IDLE next cycle.
  - Counter `cnt` (8 bit) is 0 in the first BUSY cycle and increments on each BUSY cycle with no response.
  - Timeout: `cnt == TIMEOUT_CYC` with no `s_ack_i`/`s_err_i` → `m_err_o` = 1, slave cyc/stb forced to 0 that cycle, go to IDLE.
  - Master drops `m_cyc_i` while in BUSY → abort: go to IDLE, no ack/err, no status update.
- **DERR**: `m_err_o` = 1 for exactly one cycle, `m_dat_o` = 0, go to IDLE.
- Broadcast outputs (`s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o`) are straight pass-through from the master in every state.
- `s_ack_i` and `s_err_i` from non-selected slaves, or outside BUSY, are ignored.
- Simultaneous `s_ack_i` and `s_err_i` from the selected slave: the error wins; `m_ack_o` is suppressed.
- Error status:
  - When `err_valid_o` = 0 and any error is signalled to the master, capture cause and `m_adr_i`, and set `err_valid_o`.
  - Later errors do not overwrite the record while `err_valid_o` = 1.
  - `err_clr_i` clears `err_valid_o` next cycle.
  - An error in the same cycle as `err_clr_i` is captured: the capture wins.

## Timing
- Reset (rst = 0 at a clock edge):
  - State becomes IDLE; `cnt`, `sel_q`, `err_valid_o`, `err_cause_o`, `err_addr_o` become 0.
  - All `s_cyc_o`/`s_stb_o`, `m_ack_o`, `m_err_o` are 0; `m_dat_o` = 0.
  - A reset mid-transaction abandons it with no response.
- Request accepted in cycle 0:
  - Slave strobe is first visible in cycle 1.
  - Minimum ack is cycle 1, for a combinational-ack slave.
  - Unmapped error occurs in cycle 1.
  - Timeout error occurs in cycle `TIMEOUT_CYC+1`.
- `m_ack_o`/`m_err_o` are single-cycle pulses per transaction.
- A new request may be accepted in the cycle immediately after a response (back-to-back spacing of 2 cycles minimum).
- One outstanding transaction only; no pipelining.

## Test plan
- Read from 0x0000_0010, slave 0 acks in the first BUSY cycle with 0xDEADBEEF:
  - `s_cyc_o` = 4'b0001 in cycle 1.
  - `m_ack_o` = 1 and `m_dat_o` = 0xDEADBEEF in cycle 1.
  - IDLE in cycle 2.
- Write to 0x2000_0104 with sel 4'b0011; slave 2 acks after 3 wait cycles:
  - Only `s_stb_o[2]` is asserted, for 4 cycles.
  - `m_ack_o` pulses in cycle 4.
  - `err_valid_o` stays 0.
- Read from unmapped 0x4000_0000:
  - `m_err_o` = 1 in cycle 1 only; no slave strobe.
  - `err_valid_o` = 1, `err_cause_o` = 01, `err_addr_o` = 0x4000_0000.
- Read from 0x2000_0200, slave 3 never acks:
  - `m_err_o` pulses in cycle 16.
  - `s_stb_o[3]` is high in cycles 1-15 and low in cycle 16.
  - `err_cause_o` = 10; a second error leaves the record unchanged until `err_clr_i`.
- Slave 1 asserts ack and err together at 0x2000_0000:
  - `m_err_o` = 1, `m_ack_o` = 0, `err_cause_o` = 11.
- `m_cyc_i` dropped in cycle 3 of a stalled slave-0 access, then rst = 0 mid-BUSY on a retry:
  - Neither case produces a response pulse.
  - State is IDLE and all outputs are at their reset values afterward.
